// File: rtl/wr_addr_ctrl_pkg.sv
// Shared definitions for the frame-ring write address controller.
package wr_addr_ctrl_pkg;

    // Request FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    // Width of the saturating lost-vsync counter.
    localparam int DROP_CNT_W = 16;

endpackage : wr_addr_ctrl_pkg

// File: rtl/sync_rise_det.sv
// Synchronises an asynchronous level into clk and emits a 1-cycle pulse on its rising edge.
module sync_rise_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_async,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Metastability chain followed by one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the previous value, forming a true shift chain.
            sync_q <= {sync_q[STAGES-2:0], d_async};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule : sync_rise_det

// File: rtl/wr_frame_ring_addr_ctrl.sv
// Frame-ring write address controller: one address/length request per input frame,
// skipping the block the reader owns, and publishing the last completed block.
module wr_frame_ring_addr_ctrl
    import wr_addr_ctrl_pkg::*;
#(
    parameter int          N_FRAMES     = 4,
    parameter logic [31:0] START_ADDR   = 32'h0000_0000,
    parameter logic [31:0] BLOCK_SIZE   = 32'h0008_0000,
    parameter logic [31:0] WR_NUM       = 32'd3600,
    parameter int          ADDR_WIDTH   = 30,
    parameter int          WR_NUM_WIDTH = 28,
    parameter int          ADDR_SHIFT   = 2,
    parameter int          SYNC_STAGES  = 2,
    parameter int          IDX_W        = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_vs,
    input  logic                    wr_ddr_done,
    input  logic                    wr_addr_ready,
    input  logic                    freeze,
    input  logic [IDX_W-1:0]        rd_frame_idx,
    output logic                    wr_addr_valid,
    output logic [ADDR_WIDTH-1:0]   wr_ddr_addr,
    output logic [WR_NUM_WIDTH-1:0] wr_ddr_num,
    output logic [IDX_W-1:0]        wr_frame_idx,
    output logic [IDX_W-1:0]        last_frame_idx,
    output logic                    last_frame_vld,
    output logic [DROP_CNT_W-1:0]   frame_drop_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FRAMES - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    // Edge pulses from the asynchronous inputs.
    logic vs_rise;
    logic done_rise;

    sync_rise_det #(.STAGES(SYNC_STAGES)) u_vs_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (wr_vs),
        .rise    (vs_rise)
    );

    sync_rise_det #(.STAGES(SYNC_STAGES)) u_done_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (wr_ddr_done),
        .rise    (done_rise)
    );

    // Registered state and outputs.
    state_e                  state_q;
    logic                    pend_q;
    logic                    wr_addr_valid_q;
    logic [ADDR_WIDTH-1:0]   wr_ddr_addr_q;
    logic [IDX_W-1:0]        wr_frame_idx_q;
    logic [IDX_W-1:0]        last_frame_idx_q;
    logic                    last_frame_vld_q;
    logic [DROP_CNT_W-1:0]   drop_cnt_q;

    // Next-block candidates; the address is derived from registered index and reader index only.
    logic [IDX_W-1:0]      inc_idx;
    logic [IDX_W-1:0]      next_idx_d;
    logic [31:0]           word_addr;
    logic [ADDR_WIDTH-1:0] wr_ddr_addr_d;

    // Pick the next ring block, stepping over the reader's block, and form its byte address.
    always_comb begin
        // NOTE: every signal gets a value on every path here, so no latch is inferred.
        inc_idx    = (wr_frame_idx_q == LAST_IDX) ? '0 : wr_frame_idx_q + ONE_IDX;
        next_idx_d = inc_idx;
        if (inc_idx == rd_frame_idx) begin
            next_idx_d = (inc_idx == LAST_IDX) ? '0 : inc_idx + ONE_IDX;
        end
        word_addr     = START_ADDR + 32'(next_idx_d) * BLOCK_SIZE;
        wr_ddr_addr_d = ADDR_WIDTH'(word_addr << ADDR_SHIFT);
    end

    // Request FSM with registered outputs, pending-frame tracking and drop counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            pend_q           <= 1'b0;
            wr_addr_valid_q  <= 1'b0;
            wr_ddr_addr_q    <= '0;
            wr_frame_idx_q   <= '0;
            last_frame_idx_q <= '0;
            last_frame_vld_q <= 1'b0;
            drop_cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((vs_rise || pend_q) && !freeze) begin
                        state_q         <= ST_ISSUE;
                        wr_addr_valid_q <= 1'b1;
                        wr_frame_idx_q  <= next_idx_d;
                        wr_ddr_addr_q   <= wr_ddr_addr_d;
                        pend_q          <= 1'b0;
                    end else if (freeze) begin
                        // A frozen ring forgets any frame waiting to launch.
                        pend_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (wr_addr_ready) begin
                        state_q         <= ST_BUSY;
                        wr_addr_valid_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (done_rise) begin
                        state_q          <= ST_IDLE;
                        last_frame_idx_q <= wr_frame_idx_q;
                        last_frame_vld_q <= 1'b1;
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    wr_addr_valid_q <= 1'b0;
                end
            endcase

            // While a request is in flight, hold one frame back and count any beyond that.
            if (state_q != ST_IDLE && vs_rise) begin
                if (!pend_q) begin
                    pend_q <= 1'b1;
                end else if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
                end
            end
        end
    end

    assign wr_addr_valid  = wr_addr_valid_q;
    assign wr_ddr_addr    = wr_ddr_addr_q;
    assign wr_ddr_num     = WR_NUM_WIDTH'(WR_NUM);
    assign wr_frame_idx   = wr_frame_idx_q;
    assign last_frame_idx = last_frame_idx_q;
    assign last_frame_vld = last_frame_vld_q;
    assign frame_drop_cnt = drop_cnt_q;

endmodule : wr_frame_ring_addr_ctrl

// File: tb/tb_wr_frame_ring_addr_ctrl.sv
// Directed bench for wr_frame_ring_addr_ctrl with default parameters.
module tb_wr_frame_ring_addr_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wr_vs;
    logic        wr_ddr_done;
    logic        wr_addr_ready;
    logic        freeze;
    logic [4:0]  rd_frame_idx;
    logic        wr_addr_valid;
    logic [29:0] wr_ddr_addr;
    logic [27:0] wr_ddr_num;
    logic [4:0]  wr_frame_idx;
    logic [4:0]  last_frame_idx;
    logic        last_frame_vld;
    logic [15:0] frame_drop_cnt;

    int tests = 0;
    int fails = 0;

    wr_frame_ring_addr_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_vs          (wr_vs),
        .wr_ddr_done    (wr_ddr_done),
        .wr_addr_ready  (wr_addr_ready),
        .freeze         (freeze),
        .rd_frame_idx   (rd_frame_idx),
        .wr_addr_valid  (wr_addr_valid),
        .wr_ddr_addr    (wr_ddr_addr),
        .wr_ddr_num     (wr_ddr_num),
        .wr_frame_idx   (wr_frame_idx),
        .last_frame_idx (last_frame_idx),
        .last_frame_vld (last_frame_vld),
        .frame_drop_cnt (frame_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  exp_idx;
        logic [29:0] exp_addr;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Sample valid on falling edges until it rises or the budget runs out.
    task automatic wait_valid(input int max_cyc, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (wr_addr_valid) seen = 1'b1;
        end
    endtask

    task automatic pulse_vs();
        @(negedge clk) wr_vs = 1'b1;
        repeat (3) @(negedge clk);
        wr_vs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_done();
        @(negedge clk) wr_ddr_done = 1'b1;
        repeat (3) @(negedge clk);
        wr_ddr_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // One complete frame with ready held high: request, acceptance, completion.
    task automatic frame_req(input logic [4:0] rd, input logic [4:0] exp_idx,
                             input logic [29:0] exp_addr, input string tag);
        logic seen;
        rd_frame_idx = rd;
        @(negedge clk) wr_vs = 1'b1;
        wait_valid(8, seen);
        check({tag, " valid"}, 32'(seen), 32'd1);
        check({tag, " idx"}, 32'(wr_frame_idx), 32'(exp_idx));
        check({tag, " addr"}, 32'(wr_ddr_addr), 32'(exp_addr));
        check({tag, " num"}, 32'(wr_ddr_num), 32'd3600);
        wr_vs = 1'b0;
        @(negedge clk);
        check({tag, " valid drop"}, 32'(wr_addr_valid), 32'd0);
        pulse_done();
        check({tag, " last idx"}, 32'(last_frame_idx), 32'(exp_idx));
        check({tag, " last vld"}, 32'(last_frame_vld), 32'd1);
    endtask

    initial begin
        logic        seen;
        logic        any_valid;

        // Ring walk with reader on 0, then reader on 2 with wrap.
        vecs[0] = '{5'd0, 5'd1, 30'h020_0000};
        vecs[1] = '{5'd0, 5'd2, 30'h040_0000};
        vecs[2] = '{5'd0, 5'd3, 30'h060_0000};
        vecs[3] = '{5'd0, 5'd1, 30'h020_0000};
        vecs[4] = '{5'd0, 5'd2, 30'h040_0000};
        vecs[5] = '{5'd0, 5'd3, 30'h060_0000};
        vecs[6] = '{5'd2, 5'd0, 30'h000_0000};
        vecs[7] = '{5'd2, 5'd1, 30'h020_0000};
        vecs[8] = '{5'd2, 5'd3, 30'h060_0000};
        vecs[9] = '{5'd2, 5'd0, 30'h000_0000};

        rst_n         = 1'b0;
        wr_vs         = 1'b0;
        wr_ddr_done   = 1'b0;
        wr_addr_ready = 1'b1;
        freeze        = 1'b0;
        rd_frame_idx  = 5'd0;

        repeat (3) @(negedge clk);
        check("reset valid", 32'(wr_addr_valid), 32'd0);
        check("reset addr", 32'(wr_ddr_addr), 32'd0);
        check("reset num", 32'(wr_ddr_num), 32'd3600);
        check("reset idx", 32'(wr_frame_idx), 32'd0);
        check("reset last idx", 32'(last_frame_idx), 32'd0);
        check("reset last vld", 32'(last_frame_vld), 32'd0);
        check("reset drop", 32'(frame_drop_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven ring sequence.
        for (int i = 0; i < 10; i++) begin
            frame_req(vecs[i].rd, vecs[i].exp_idx, vecs[i].exp_addr, $sformatf("vec%0d", i));
        end

        // Backpressure: request must hold while ready is low.
        rd_frame_idx  = 5'd0;
        wr_addr_ready = 1'b0;
        @(negedge clk) wr_vs = 1'b1;
        wait_valid(8, seen);
        check("bp valid", 32'(seen), 32'd1);
        check("bp idx", 32'(wr_frame_idx), 32'd1);
        wr_vs = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp hold valid c%0d", i), 32'(wr_addr_valid), 32'd1);
            check($sformatf("bp hold addr c%0d", i), 32'(wr_ddr_addr), 32'h020_0000);
        end
        wr_addr_ready = 1'b1;
        @(negedge clk);
        check("bp valid after accept", 32'(wr_addr_valid), 32'd0);
        pulse_done();
        check("bp last idx", 32'(last_frame_idx), 32'd1);

        // Two vsyncs while busy: one pends, one is dropped; pending launches after done.
        @(negedge clk) wr_vs = 1'b1;
        wait_valid(8, seen);
        check("pend first valid", 32'(seen), 32'd1);
        check("pend first idx", 32'(wr_frame_idx), 32'd2);
        wr_vs = 1'b0;
        repeat (3) @(negedge clk);
        pulse_vs();
        check("pend drop after one", 32'(frame_drop_cnt), 32'd0);
        pulse_vs();
        check("pend drop after two", 32'(frame_drop_cnt), 32'd1);
        @(negedge clk) wr_ddr_done = 1'b1;
        repeat (3) @(negedge clk);
        check("pend valid while idle", 32'(wr_addr_valid), 32'd0);
        check("pend last idx", 32'(last_frame_idx), 32'd2);
        @(negedge clk);
        check("pend launch valid", 32'(wr_addr_valid), 32'd1);
        check("pend launch idx", 32'(wr_frame_idx), 32'd3);
        check("pend launch addr", 32'(wr_ddr_addr), 32'h060_0000);
        wr_ddr_done = 1'b0;
        @(negedge clk);
        check("pend launch accepted", 32'(wr_addr_valid), 32'd0);
        repeat (3) @(negedge clk);
        pulse_done();
        check("pend done last idx", 32'(last_frame_idx), 32'd3);

        // Freeze: vsyncs in idle are discarded, not counted, and leave nothing pending.
        freeze    = 1'b1;
        any_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk) wr_vs = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (wr_addr_valid) any_valid = 1'b1;
            end
            wr_vs = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (wr_addr_valid) any_valid = 1'b1;
            end
        end
        freeze = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wr_addr_valid) any_valid = 1'b1;
        end
        check("freeze no request", 32'(any_valid), 32'd0);
        check("freeze drop unchanged", 32'(frame_drop_cnt), 32'd1);
        frame_req(5'd0, 5'd1, 30'h020_0000, "unfreeze");

        // Asynchronous reset while busy.
        @(negedge clk) wr_vs = 1'b1;
        wait_valid(8, seen);
        check("rst pre valid", 32'(seen), 32'd1);
        check("rst pre idx", 32'(wr_frame_idx), 32'd2);
        wr_vs = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst valid", 32'(wr_addr_valid), 32'd0);
        check("async rst addr", 32'(wr_ddr_addr), 32'd0);
        check("async rst idx", 32'(wr_frame_idx), 32'd0);
        check("async rst last idx", 32'(last_frame_idx), 32'd0);
        check("async rst last vld", 32'(last_frame_vld), 32'd0);
        check("async rst drop", 32'(frame_drop_cnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post rst last vld", 32'(last_frame_vld), 32'd0);
        check("post rst num", 32'(wr_ddr_num), 32'd3600);

        // Done in idle is ignored.
        pulse_done();
        check("idle done ignored", 32'(last_frame_vld), 32'd0);

        // First frame after reset with the reader on block 1 goes to block 2.
        frame_req(5'd1, 5'd2, 30'h040_0000, "first rd1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_wr_frame_ring_addr_ctrl
